// File: rtl/adc_capture_ctrl_if.sv
// ADC pin and corrected-sample stream bundle for adc_capture_ctrl.
// The master side is the capture controller; the slave side is the ADC plus the downstream FIFO.
interface adc_capture_ctrl_if #(
  parameter int DW = 16
);
  logic          adc_convst;
  logic          adc_busy;
  logic [DW-1:0] adc_di;
  logic [DW-1:0] adc_do;
  logic          adc_do_valid;
  logic          adc_do_sat;

  modport master (
    output adc_convst,
    output adc_do,
    output adc_do_valid,
    output adc_do_sat,
    input  adc_busy,
    input  adc_di
  );

  modport slave (
    input  adc_convst,
    input  adc_do,
    input  adc_do_valid,
    input  adc_do_sat,
    output adc_busy,
    output adc_di
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// CONVST/BUSY handshake controller with pixel windowing and an offset/saturation
// correction pipeline for busy-handshake parallel ADCs.
module adc_capture_ctrl #(
  parameter int DW        = 16,
  parameter int CNT_W     = 16,
  parameter int WIN_START = 34,
  parameter int WIN_END   = 2081,
  parameter int CONVST_W  = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 adc_restart,
  input  logic                 adc_start,
  input  logic [DW-1:0]        cfg_offset,
  input  logic [DW-1:0]        cfg_maxsat,
  output logic [CNT_W-1:0]     pixel_cnt,
  output logic                 err_timeout,
  output logic                 err_overrun,
  adc_capture_ctrl_if.master   adc
);

  localparam int TMR_MAX = (TIMEOUT > CONVST_W) ? TIMEOUT : CONVST_W;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] CONV_LAST = TMR_W'(CONVST_W - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(WIN_START);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(WIN_END);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [TMR_W-1:0]   timer_r, timer_nx_s;
  logic               convst_r, convst_nx_s;
  logic [CNT_W-1:0]   pix_idx_r, pix_idx_nx_s;
  logic [CNT_W-1:0]   pixel_cnt_r;
  logic               err_timeout_r, err_overrun_r;
  logic               cap_s, tmo_s, ovr_s;

  logic               busy_meta_r, busy_sync_r, busy_prev_r;
  logic               busy_fall_s;

  logic [DW-1:0]      s1_raw_r;
  logic               s1_win_r, s1_valid_r;
  logic signed [DW:0] diff_s;
  logic [DW-1:0]      do_nx_s;
  logic               sat_nx_s;
  logic [DW-1:0]      do_r;
  logic               do_valid_r, do_sat_r;

  // Two-flop synchroniser for the asynchronous BUSY pin plus an edge-history flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_meta_r <= 1'b0;
      busy_sync_r <= 1'b0;
      busy_prev_r <= 1'b0;
    end else begin
      busy_meta_r <= adc.adc_busy;
      busy_sync_r <= busy_meta_r;
      busy_prev_r <= busy_sync_r;
    end
  end

  assign busy_fall_s = !busy_sync_r && busy_prev_r;
  assign ovr_s       = adc_start && !adc_restart && (state_r != ST_IDLE);

  // Handshake FSM next-state logic; one timer serves both the CONVST width and the BUSY timeout.
  always_comb begin
    state_nx_s   = state_r;
    timer_nx_s   = timer_r;
    convst_nx_s  = convst_r;
    pix_idx_nx_s = pix_idx_r;
    cap_s        = 1'b0;
    tmo_s        = 1'b0;
    if (adc_restart) begin
      state_nx_s  = ST_IDLE;
      timer_nx_s  = '0;
      convst_nx_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (adc_start) begin
            pix_idx_nx_s = pixel_cnt_r;
            convst_nx_s  = 1'b0;
            timer_nx_s   = '0;
            state_nx_s   = ST_CONV;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CONV: begin
          if (timer_r == CONV_LAST) begin
            convst_nx_s = 1'b1;
            timer_nx_s  = '0;
            state_nx_s  = ST_WAIT_HI;
          end else begin
            timer_nx_s = timer_r + TMR_ONE;
          end
        end
        ST_WAIT_HI: begin
          if (timer_r == TO_LAST) begin
            tmo_s      = 1'b1;
            state_nx_s = ST_IDLE;
          end else if (busy_sync_r) begin
            timer_nx_s = timer_r + TMR_ONE;
            state_nx_s = ST_WAIT_LO;
          end else begin
            timer_nx_s = timer_r + TMR_ONE;
          end
        end
        ST_WAIT_LO: begin
          // A falling edge seen on the last allowed cycle still counts as a good sample.
          if (busy_fall_s) begin
            cap_s      = 1'b1;
            state_nx_s = ST_IDLE;
          end else if (timer_r == TO_LAST) begin
            tmo_s      = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            timer_nx_s = timer_r + TMR_ONE;
          end
        end
        default: begin
          state_nx_s  = ST_IDLE;
          convst_nx_s = 1'b1;
          timer_nx_s  = '0;
        end
      endcase
    end
  end

  // FSM state, timer, CONVST and latched pixel index registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      convst_r  <= 1'b1;
      pix_idx_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      timer_r   <= timer_nx_s;
      convst_r  <= convst_nx_s;
      pix_idx_r <= pix_idx_nx_s;
    end
  end

  // Saturating pixel counter and sticky error flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pixel_cnt_r   <= '0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else if (adc_restart) begin
      pixel_cnt_r   <= '0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      if (adc_start && !(&pixel_cnt_r)) begin
        pixel_cnt_r <= pixel_cnt_r + CNT_ONE;
      end
      if (tmo_s) begin
        err_timeout_r <= 1'b1;
      end
      if (ovr_s) begin
        err_overrun_r <= 1'b1;
      end
    end
  end

  // Stage 1: raw sample, window flag and valid bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_raw_r   <= '0;
      s1_win_r   <= 1'b0;
      s1_valid_r <= 1'b0;
    end else if (adc_restart) begin
      s1_raw_r   <= '0;
      s1_win_r   <= 1'b0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= cap_s;
      if (cap_s) begin
        s1_raw_r <= adc.adc_di;
        s1_win_r <= (pix_idx_r >= WIN_LO) && (pix_idx_r <= WIN_HI);
      end
    end
  end

  // Offset subtraction with clamp-at-zero and saturation ceiling.
  always_comb begin
    diff_s   = $signed({1'b0, s1_raw_r}) - $signed({1'b0, cfg_offset});
    do_nx_s  = '0;
    sat_nx_s = 1'b0;
    if (diff_s[DW]) begin
      do_nx_s  = '0;
      sat_nx_s = 1'b0;
    end else if (diff_s > $signed({1'b0, cfg_maxsat})) begin
      do_nx_s  = cfg_maxsat;
      sat_nx_s = 1'b1;
    end else begin
      do_nx_s  = diff_s[DW-1:0];
      sat_nx_s = 1'b0;
    end
  end

  // Stage 2 output registers; data holds between valid beats.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      do_r       <= '0;
      do_valid_r <= 1'b0;
      do_sat_r   <= 1'b0;
    end else if (adc_restart) begin
      do_r       <= '0;
      do_valid_r <= 1'b0;
      do_sat_r   <= 1'b0;
    end else begin
      do_valid_r <= s1_valid_r && s1_win_r;
      if (s1_valid_r && s1_win_r) begin
        do_r     <= do_nx_s;
        do_sat_r <= sat_nx_s;
      end
    end
  end

  assign adc.adc_convst   = convst_r;
  assign adc.adc_do       = do_r;
  assign adc.adc_do_valid = do_valid_r;
  assign adc.adc_do_sat   = do_sat_r;
  assign pixel_cnt        = pixel_cnt_r;
  assign err_timeout      = err_timeout_r;
  assign err_overrun      = err_overrun_r;

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Parametrised conversion controller and pixel capture block for busy-handshake parallel ADCs (AD7621 class), for the line-sensor readout path. It issues CONVST per pixel strobe, tracks ADC BUSY through an explicit state machine with timeout, and counts pixels to gate an active window. Captured samples are offset-corrected with clamp-at-zero, limited to a saturation ceiling, and delivered as a single-cycle valid stream to the downstream FIFO.

Parameters:
DW, 16, ADC data width and output width
CNT_W, 16, pixel counter width
WIN_START, 34, first pixel index forwarded (inclusive)
WIN_END, 2081, last pixel index forwarded (inclusive)
CONVST_W, 3, CONVST low pulse width in sys_clk cycles (>=1)
TIMEOUT, 255, max cycles allowed from CONVST release to BUSY falling edge (>=2)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
adc_restart  in  1  synchronous line restart, active-high
adc_start  in  1  pixel conversion request, single-cycle pulse
adc_busy  in  1  ADC BUSY, asynchronous to sys_clk
adc_di  in  DW  ADC parallel data
cfg_offset  in  DW  dark offset, quasi-static
cfg_maxsat  in  DW  saturation ceiling, quasi-static
adc_convst  out  1  ADC CONVST, active-low
adc_do  out  DW  corrected sample
adc_do_valid  out  1  one-cycle qualifier for adc_do
adc_do_sat  out  1  adc_do was limited to cfg_maxsat, qualified by adc_do_valid
pixel_cnt  out  CNT_W  pixel strobes seen since restart
err_timeout  out  1  sticky, BUSY handshake timed out
err_overrun  out  1  sticky, adc_start arrived while not IDLE

Behaviour:
- Reset (sys_rst_n low, async) and adc_restart (sync): FSM=IDLE, adc_convst=1, adc_do=0, adc_do_valid=0, adc_do_sat=0, pixel_cnt=0, err flags=0, timer=0, pipeline flushed. adc_restart beats adc_start in the same cycle, and the start is dropped.
- adc_busy passes through a 2-FF synchroniser (busy_s). Falling edge = busy_s low and previous busy_s high.
- pixel_cnt: +1 on every adc_start, including overrun starts. It holds at all-ones and does not wrap.
- FSM:
  IDLE: on adc_start, latch pix_idx = pixel_cnt (pre-increment), adc_convst<=0, go to CONV.
  CONV: adc_convst held low for exactly CONVST_W cycles, then adc_convst<=1, timer<=0, go to WAIT_HI.
  WAIT_HI: wait for busy_s=1, then go to WAIT_LO. timer increments.
  WAIT_LO: on falling edge, capture adc_di and pix_idx into stage-1 and go to IDLE. timer increments.
  Timeout: if timer reaches TIMEOUT in WAIT_HI or WAIT_LO, set err_timeout, go to IDLE, no sample produced.
- adc_start while FSM != IDLE: ignored for conversion, err_overrun<=1.
- Datapath, 2 stages:
  Stage 1 registers the raw sample, a window flag (WIN_START <= pix_idx <= WIN_END), and a valid bit.
  Stage 2 computes diff = raw - cfg_offset at DW+1 bits signed. If diff<0, adc_do=0. If diff>cfg_maxsat, adc_do=cfg_maxsat and adc_do_sat=1. Otherwise adc_do=diff and adc_do_sat=0.
- adc_do_valid is high for 1 cycle only when stage 1 is valid and inside the window.
- Latency: adc_do_valid asserts 2 clock edges after the edge at which busy_s is first sampled low.
- Out-of-window samples run the full handshake but produce no valid. adc_do holds its last value when not valid.

Test Plan:
- DW=16, offset=0x0100, maxsat=0x0F00: pixels 0..40 with adc_di=0x0500 -> exactly 7 valids (indices 34..40), adc_do=0x0400, sat=0, pixel_cnt=41. Check CONVST low for 3 cycles per start and valid at edge+2.
- adc_di=0x0080, offset 0x0100 -> adc_do=0x0000 (clamped, not wrapped), sat=0. adc_di=0xFFFF -> adc_do=0x0F00, sat=1.
- BUSY held low after CONVST -> err_timeout=1 exactly TIMEOUT cycles after CONVST release, no valid, FSM back to IDLE and the next start converts normally.
- Second adc_start during WAIT_LO -> err_overrun=1, only one CONVST pulse, pixel_cnt still +2, one sample out.
- adc_restart mid-WAIT_LO and coincident with adc_start -> convst=1, pixel_cnt=0, flags cleared, no valid. The coincident start is dropped and the next start gets pix_idx=0.
- Async assert of sys_rst_n during CONV -> adc_convst=1 immediately without a clock edge. All outputs at reset values.
